// File: rtl/shift_rotate_seq.sv
// 8088 shift/rotate sequencer driving a shared 16-bit left-rotator; ROT ops 2 cycles, RCL/RCR n+1, zero count 1.
// Result is held in DONE until res_ready; start_ready only in IDLE, so no new op is taken while a result waits.
module shift_rotate_seq #(
  parameter int W_DATA = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [2:0]        op,
  input  logic              byte_mode,
  input  logic [W_DATA-1:0] data_in,
  input  logic [7:0]        count,
  input  logic              cf_in,
  output logic [W_DATA-1:0] rot_a,
  output logic [3:0]        rot_op,
  input  logic [W_DATA-1:0] rot_r,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W_DATA-1:0] result,
  output logic              cf_out,
  output logic              of_out,
  output logic              of_valid
);

  typedef enum logic [1:0] {IDLE, ROT, ITER, DONE} state_t;

  localparam logic [2:0] OP_ROL = 3'd0, OP_ROR = 3'd1, OP_SHL = 3'd2, OP_SHR = 3'd3,
                         OP_SAR = 3'd4, OP_RCL = 3'd5, OP_RCR = 3'd6;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic        byte_q;
  logic [15:0] data_q;
  logic [7:0]  count_q;
  logic [3:0]  n_q;
  logic [4:0]  rem_q;
  logic [15:0] x_q;
  logic        c_q;

  logic [2:0]  op_eff;
  logic        is_rc_in, accept, zero_in;
  logic [4:0]  n_rc_in;
  logic [3:0]  n_in;

  logic [15:0] wmask, rr, low_mask, top_mask, res_w, rot_res;
  logic [4:0]  wbits, cnt;
  logic [3:0]  shl_idx, shr_idx;
  logic        sign_bit, big, msb, msb2, rot_cf, rot_of;

  logic [15:0] it_x;
  logic        it_c, it_of, it_msb, it_msb2;

  assign start_ready = (state == IDLE) && !rst;
  assign res_valid   = (state == DONE);
  assign accept      = start_valid && start_ready;

  always_comb begin
    op_eff   = (op == 3'd7) ? OP_ROL : op;
    is_rc_in = (op_eff == OP_RCL) || (op_eff == OP_RCR);
    n_rc_in  = byte_mode ? 5'(count % 8'd9) : 5'(count % 8'd17);
    // ROL/ROR reduce mod W; shifts keep the raw count and rely on masking.
    if (op_eff == OP_ROL || op_eff == OP_ROR)
      n_in = byte_mode ? {1'b0, count[2:0]} : count[3:0];
    else
      n_in = count[3:0];
    zero_in = (count == 8'd0) || (is_rc_in && n_rc_in == 5'd0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_in ? DONE : (is_rc_in ? ITER : ROT);
      ROT:  state_nxt = DONE;
      ITER: if (rem_q == 5'd1) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    rot_a  = 16'h0000;
    rot_op = 4'd0;
    if (state == ROT) begin
      rot_a  = byte_q ? {data_q[7:0], data_q[7:0]} : data_q;
      rot_op = (op_q == OP_ROL || op_q == OP_SHL) ? n_q : 4'd0 - n_q;
    end
  end

  always_comb begin
    wmask    = byte_q ? 16'h00FF : 16'hFFFF;
    wbits    = byte_q ? 5'd8 : 5'd16;
    sign_bit = byte_q ? data_q[7] : data_q[15];
    big      = count_q > {3'b000, wbits};
    cnt      = count_q[4:0];
    shl_idx  = 4'(wbits - cnt);
    shr_idx  = 4'(cnt - 5'd1);
    rr       = rot_r & wmask;
    low_mask = (16'h0001 << cnt) - 16'h0001;
    top_mask = ~(wmask >> cnt) & wmask;
    res_w    = rr;
    rot_cf   = 1'b0;
    case (op_q)
      OP_SHL: begin
        res_w  = big ? 16'h0000 : (rr & ~low_mask);
        rot_cf = big ? 1'b0 : data_q[shl_idx];
      end
      OP_SHR: begin
        res_w  = big ? 16'h0000 : (rr & ~top_mask);
        rot_cf = big ? 1'b0 : data_q[shr_idx];
      end
      OP_SAR: begin
        if (big) begin
          res_w  = sign_bit ? wmask : 16'h0000;
          rot_cf = sign_bit;
        end else begin
          res_w  = sign_bit ? (rr | top_mask) : (rr & ~top_mask);
          rot_cf = data_q[shr_idx];
        end
      end
      OP_ROR:  rot_cf = byte_q ? rr[7] : rr[15];
      default: rot_cf = rr[0];
    endcase
    msb    = byte_q ? res_w[7] : res_w[15];
    msb2   = byte_q ? res_w[6] : res_w[14];
    rot_of = 1'b0;
    if (count_q == 8'd1) begin
      case (op_q)
        OP_ROL, OP_SHL: rot_of = msb ^ rot_cf;
        OP_ROR:         rot_of = msb ^ msb2;
        OP_SHR:         rot_of = sign_bit;
        default:        rot_of = 1'b0;
      endcase
    end
    rot_res = byte_q ? {data_q[15:8], res_w[7:0]} : res_w;
  end

  // One bit of rotate-through-carry over W+1 bits; in byte mode x_q[15:8] keeps data_in[15:8].
  always_comb begin
    it_x = x_q;
    it_c = c_q;
    if (op_q == OP_RCL) begin
      if (byte_q) {it_c, it_x[7:0]} = {x_q[7:0], c_q};
      else        {it_c, it_x}      = {x_q, c_q};
    end else begin
      if (byte_q) {it_x[7:0], it_c} = {c_q, x_q[7:0]};
      else        {it_x, it_c}      = {c_q, x_q};
    end
    it_msb  = byte_q ? it_x[7] : it_x[15];
    it_msb2 = byte_q ? it_x[6] : it_x[14];
    it_of   = 1'b0;
    if (count_q == 8'd1)
      it_of = (op_q == OP_RCL) ? (it_msb ^ it_c) : (it_msb ^ it_msb2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_ROL;
      byte_q   <= 1'b0;
      data_q   <= 16'h0000;
      count_q  <= 8'd0;
      n_q      <= 4'd0;
      rem_q    <= 5'd0;
      x_q      <= 16'h0000;
      c_q      <= 1'b0;
      result   <= 16'h0000;
      cf_out   <= 1'b0;
      of_out   <= 1'b0;
      of_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q    <= op_eff;
          byte_q  <= byte_mode;
          data_q  <= data_in;
          count_q <= count;
          n_q     <= n_in;
          rem_q   <= n_rc_in;
          x_q     <= data_in;
          c_q     <= cf_in;
          if (zero_in) begin
            result   <= data_in;
            cf_out   <= cf_in;
            of_out   <= 1'b0;
            of_valid <= 1'b0;
          end
        end
        ROT: begin
          result   <= rot_res;
          cf_out   <= rot_cf;
          of_out   <= rot_of;
          of_valid <= (count_q == 8'd1);
        end
        ITER: begin
          x_q   <= it_x;
          c_q   <= it_c;
          rem_q <= rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            result   <= it_x;
            cf_out   <= it_c;
            of_out   <= it_of;
            of_valid <= (count_q == 8'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shift_rotate_seq.md
Name: shift_rotate_seq

Overview:
Sequencer for the 8088 ALU shift/rotate group (ROL, ROR, SHL, SHR, SAR, RCL, RCR). It accepts one operation per valid/ready handshake and drives the shared 16-bit combinational left-rotator through the rot_a/rot_op/rot_r ports. It applies the masking, byte-mode and oversize-count rules, runs RCL/RCR bit-serially through carry, and returns the result with CF/OF through a second valid/ready handshake. It sits between the execution-unit decoder and the ALU flag/writeback logic.

Parameters:
W_DATA, 16, datapath width; fixed, because the rotator is 16-bit.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start_valid  in  1  operation request
start_ready  out  1  high only in IDLE and when rst=0
op  in  3  0=ROL 1=ROR 2=SHL 3=SHR 4=SAR 5=RCL 6=RCR; 7 is treated as ROL
byte_mode  in  1  1 = operate on data_in[7:0] (W=8), else W=16
data_in  in  16  operand
count  in  8  shift count (CL or 1); not masked to 5 bits
cf_in  in  1  current CF
rot_a  out  16  rotator operand
rot_op  out  4  rotator left-rotate amount
rot_r  in  16  rotator result; combinational, same cycle
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
result  out  16  result; in byte mode, [15:8] = data_in[15:8]
cf_out  out  1  new CF
of_out  out  1  new OF
of_valid  out  1  1 iff count==1 (OF defined)

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- States: IDLE, ROT, ITER, DONE. Reset, including mid-operation, forces:
  - state=IDLE
  - res_valid=0, result=0, cf_out=0, of_out=0, of_valid=0
  - rot_a=0, rot_op=0
  - any in-flight operation is dropped.
- Accept: start_valid && start_ready at an edge latches op, byte_mode, data_in, count, cf_in.
- Transitions out of IDLE on accept:
  - ROL/ROR/SHL/SHR/SAR go to ROT.
  - RCL/RCR with n>0 go to ITER.
  - count==0, or RCL/RCR with n==0, go directly to DONE with result=data_in and cf_out=cf_in.
- Effective count n:
  - ROL/ROR: count mod W.
  - Shifts: count.
  - RCL/RCR: count mod (W+1).
- ROT (exactly 1 cycle):
  - rot_a = data_in in word mode; {b,b} in byte mode, where b = data_in[7:0].
  - rot_op = n[3:0] for ROL/SHL; (16-n)[3:0] for ROR/SHR/SAR.
  - Take rot_r (low W bits) and mask it:
    - SHL: clear low n bits.
    - SHR: clear top n bits.
    - SAR: fill top n bits with the sign bit.
  - Shift with count>W: result 0 (SAR: all sign bits).
  - Register the result; go to DONE.
  - Outside ROT: rot_a=0, rot_op=0.
- CF rules:
  - ROL: result[0]. ROR: result[W-1]. These hold even when n==0 but count!=0.
  - SHL, count<=W: data_in[W-count]. SHR/SAR, count<=W: data_in[count-1].
  - count>W: SHL/SHR give CF=0; SAR gives the sign bit.
- ITER: one cycle per bit, n cycles. The rotator is unused.
  - RCL: {CF,x} <- {x,CF} rotated left by 1 over W+1 bits.
  - RCR: the same rotation to the right.
  - A remaining-count register decrements; at 0, go to DONE.
- OF, when count==1 (of_valid=1); otherwise of_out=0 and of_valid=0:
  - ROL/SHL/RCL: result[W-1]^cf_out.
  - ROR/RCR: result[W-1]^result[W-2].
  - SHR: data_in[W-1].
  - SAR: 0.
- Latency, with accept at edge T:
  - ROT ops: res_valid high from T+2.
  - RCx: res_valid from T+n+1.
  - Zero-count ops: res_valid from T+1.
- DONE:
  - res_valid=1. result, cf_out, of_out, of_valid are held stable while res_ready=0.
  - On res_valid && res_ready: go to IDLE. start_ready rises the next cycle; there is no accept in the same cycle.

Test Plan:
1. Word ROL, data 0x8001, count 1, accepted at T -> rot_op=1 during T+1; at T+2: res_valid=1, result 0x0003, cf_out=1, of_out=1, of_valid=1.
2. Byte ROR, data 0x12B4, count 3 -> rot_a=0xB4B4, rot_op=13; result 0x1296, cf_out=1, of_valid=0.
3. Shift counts:
   - Word SHR 0x8000, count 16 -> result 0x0000, cf_out=1.
   - Word SHR 0x8000, count 20 -> result 0x0000, cf_out=0.
   - Word SAR 0x8000, count 20 -> result 0xFFFF, cf_out=1.
4. Word RCL:
   - Data 0x8000, cf_in=0, count 2 -> result 0x0001, cf_out=0, res_valid at T+3.
   - Same with count 17 -> result 0x8000, cf_out=0, res_valid at T+1.
5. Backpressure: hold res_ready=0 for 5 cycles in DONE -> result and flags stable, start_ready=0. Raise res_ready -> next cycle IDLE, start_ready=1.
6. Reset mid-run: assert rst during the 4th ITER cycle of RCR count 10 -> next cycle res_valid=0, result=0; after rst drops, start_ready=1 and a new op completes normally.
